// File: rtl/irq_pc_pkg.sv
// Shared types and helpers for the PC / vectored-interrupt sequencer.
package irq_pc_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_ISR  = 2'd1,
    ST_ISR2 = 2'd2
  } irq_state_e;

  localparam logic [1:0] PCSRC_INC  = 2'd0;
  localparam logic [1:0] PCSRC_BR   = 2'd1;
  localparam logic [1:0] PCSRC_LINK = 2'd2;
  localparam logic [1:0] PCSRC_HOLD = 2'd3;

  // Vector address before truncation to the PC width.
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [31:0] stride,
                                           input logic [31:0] id);
    return base + (id * stride);
  endfunction

endpackage

// File: rtl/irq_pc_if.sv
// Controller-side bundle for irq_pc_unit: request lines, PC-load strobes and status.
interface irq_pc_if #(
  parameter int AW   = 9,
  parameter int NIRQ = 4
);
  localparam int IW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  logic [NIRQ-1:0] irq;
  logic [NIRQ-1:0] irq_en;
  logic            gie;
  logic            boundary;
  logic            pc_load;
  logic [1:0]      pc_src;
  logic [AW-1:0]   branch_tgt;
  logic [AW-1:0]   link_tgt;
  logic            iret;
  logic [AW-1:0]   pc;
  logic            irq_take;
  logic            irq_active;
  logic [IW-1:0]   irq_id;
  logic [NIRQ-1:0] pending;

  modport master (
    output irq, irq_en, gie, boundary, pc_load, pc_src, branch_tgt, link_tgt, iret,
    input  pc, irq_take, irq_active, irq_id, pending
  );

  modport slave (
    input  irq, irq_en, gie, boundary, pc_load, pc_src, branch_tgt, link_tgt, iret,
    output pc, irq_take, irq_active, irq_id, pending
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: index 0 is the highest priority.
module irq_prio_enc #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = {IW{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IW'(i);
      end else begin
        valid = valid;
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/irq_pc_unit.sv
// Program counter plus vectored-interrupt sequencer with edge-latched requests.
// Define IRQ_NEST_EN to allow one level of preemption (ISR2 and a 2-entry return stack).
module irq_pc_unit
  import irq_pc_pkg::*;
#(
  parameter int          AW         = 9,
  parameter int          NIRQ       = 4,
  parameter int unsigned VEC_BASE   = 32'h0000_0010,
  parameter int unsigned VEC_STRIDE = 32'd4,
  parameter int unsigned RESET_PC   = 32'd0
) (
  input  logic    clk,
  input  logic    reset,
  irq_pc_if.slave bus
);

  localparam int            IW     = (NIRQ > 1) ? $clog2(NIRQ) : 1;
  localparam logic [AW-1:0] PC_RST = AW'(RESET_PC);
  localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

  irq_state_e      state_r, state_nxt_s;
  logic [AW-1:0]   pc_r, pc_nxt_s, ret_pc_r, ret_tgt_s, vec_s;
  logic [NIRQ-1:0] pend_r, irq_prev_r, req_s, clr_s;
  logic [IW-1:0]   irq_id_r, irq_id_nxt_s, enc_idx_s;
  logic            enc_valid_s, take_s, iret_s;
  logic            irq_take_r, irq_active_r;
`ifdef IRQ_NEST_EN
  logic [AW-1:0]   ret_pc1_r;
  logic [IW-1:0]   ret_id1_r;
`endif

  assign req_s = pend_r & bus.irq_en;

  irq_prio_enc #(.N(NIRQ), .IW(IW)) u_enc (
    .req   (req_s),
    .valid (enc_valid_s),
    .idx   (enc_idx_s)
  );

  assign vec_s = AW'(vec_addr(VEC_BASE, VEC_STRIDE, 32'(enc_idx_s)));

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_RUN;
    else        state_r <= state_nxt_s;
  end

  // FSM next-state logic; iret beats a coincident preempt.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (take_s) state_nxt_s = ST_ISR;
        else        state_nxt_s = ST_RUN;
      end
      ST_ISR: begin
        if (bus.iret) state_nxt_s = ST_RUN;
`ifdef IRQ_NEST_EN
        else if (take_s) state_nxt_s = ST_ISR2;
`endif
        else state_nxt_s = ST_ISR;
      end
`ifdef IRQ_NEST_EN
      ST_ISR2: begin
        if (bus.iret) state_nxt_s = ST_ISR;
        else          state_nxt_s = ST_ISR2;
      end
`endif
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // FSM output decode: when to take an interrupt and when to honour iret.
  always_comb begin
    take_s = 1'b0;
    iret_s = 1'b0;
    case (state_r)
      ST_RUN: take_s = bus.boundary & bus.gie & enc_valid_s;
      ST_ISR: begin
        iret_s = bus.iret;
`ifdef IRQ_NEST_EN
        take_s = bus.boundary & bus.gie & enc_valid_s & (enc_idx_s < irq_id_r) & ~bus.iret;
`endif
      end
`ifdef IRQ_NEST_EN
      ST_ISR2: iret_s = bus.iret;
`endif
      default: begin
        take_s = 1'b0;
        iret_s = 1'b0;
      end
    endcase
  end

  // Next PC, serviced id and pending-clear mask; a take outranks iret and pc_load.
  always_comb begin
`ifdef IRQ_NEST_EN
    ret_tgt_s = (state_r == ST_ISR2) ? ret_pc1_r : ret_pc_r;
`else
    ret_tgt_s = ret_pc_r;
`endif
    if (take_s) begin
      pc_nxt_s = vec_s;
    end else if (iret_s) begin
      pc_nxt_s = ret_tgt_s;
    end else if (bus.pc_load) begin
      case (bus.pc_src)
        PCSRC_INC:  pc_nxt_s = pc_r + PC_ONE;
        PCSRC_BR:   pc_nxt_s = bus.branch_tgt;
        PCSRC_LINK: pc_nxt_s = bus.link_tgt;
        PCSRC_HOLD: pc_nxt_s = pc_r;
        default:    pc_nxt_s = pc_r;
      endcase
    end else begin
      pc_nxt_s = pc_r;
    end

    if (take_s) irq_id_nxt_s = enc_idx_s;
`ifdef IRQ_NEST_EN
    else if (iret_s && (state_r == ST_ISR2)) irq_id_nxt_s = ret_id1_r;
`endif
    else irq_id_nxt_s = irq_id_r;

    if (take_s) clr_s = {{(NIRQ-1){1'b0}}, 1'b1} << enc_idx_s;
    else        clr_s = {NIRQ{1'b0}};
  end

  // Datapath registers; a new edge on a channel being cleared keeps it pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r         <= PC_RST;
      pend_r       <= {NIRQ{1'b0}};
      irq_prev_r   <= {NIRQ{1'b0}};
      ret_pc_r     <= {AW{1'b0}};
      irq_id_r     <= {IW{1'b0}};
      irq_take_r   <= 1'b0;
      irq_active_r <= 1'b0;
`ifdef IRQ_NEST_EN
      ret_pc1_r    <= {AW{1'b0}};
      ret_id1_r    <= {IW{1'b0}};
`endif
    end else begin
      pc_r         <= pc_nxt_s;
      pend_r       <= (pend_r & ~clr_s) | (bus.irq & ~irq_prev_r);
      irq_prev_r   <= bus.irq;
      irq_id_r     <= irq_id_nxt_s;
      irq_take_r   <= take_s;
      irq_active_r <= (state_nxt_s != ST_RUN);
      if (take_s && (state_r == ST_RUN)) ret_pc_r <= pc_r;
`ifdef IRQ_NEST_EN
      if (take_s && (state_r == ST_ISR)) begin
        ret_pc1_r <= pc_r;
        ret_id1_r <= irq_id_r;
      end
`endif
    end
  end

  assign bus.pc         = pc_r;
  assign bus.irq_take   = irq_take_r;
  assign bus.irq_active = irq_active_r;
  assign bus.irq_id     = irq_id_r;
  assign bus.pending    = pend_r;

endmodule

// File: tb/tb_irq_pc_unit.sv
// Directed-vector bench for irq_pc_unit (default parameters; nesting checks when IRQ_NEST_EN is defined).
module tb_irq_pc_unit;

  localparam int AW   = 9;
  localparam int NIRQ = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  irq_pc_if #(.AW(AW), .NIRQ(NIRQ)) bus ();

  irq_pc_unit #(
    .AW(AW), .NIRQ(NIRQ), .VEC_BASE(32'h0000_0010), .VEC_STRIDE(32'd4), .RESET_PC(32'd0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Status after a take: pulse, vector, id, active.
  task automatic check_take(input string tag, input logic [8:0] vec, input logic [1:0] id);
    check_vec({tag, "_take"},   32'(bus.irq_take),   32'd1);
    check_vec({tag, "_pc"},     32'(bus.pc),         32'(vec));
    check_vec({tag, "_id"},     32'(bus.irq_id),     32'(id));
    check_vec({tag, "_active"}, 32'(bus.irq_active), 32'd1);
  endtask

  // One-cycle pulse on irq lines: edge sampled, then lines dropped.
  task automatic pulse_irq(input logic [3:0] lines);
    bus.irq = lines;
    step();
    bus.irq = 4'b0000;
  endtask

  initial begin
    bus.irq = 4'b0000; bus.irq_en = 4'b0000; bus.gie = 1'b0; bus.boundary = 1'b0;
    bus.pc_load = 1'b0; bus.pc_src = 2'd0; bus.branch_tgt = 9'h000; bus.link_tgt = 9'h000;
    bus.iret = 1'b0;

    #12;
    check_vec("rst_pc",      32'(bus.pc),         32'd0);
    check_vec("rst_take",    32'(bus.irq_take),   32'd0);
    check_vec("rst_active",  32'(bus.irq_active), 32'd0);
    check_vec("rst_id",      32'(bus.irq_id),     32'd0);
    check_vec("rst_pending", 32'(bus.pending),    32'd0);
    reset = 1'b1;

    // Increment and wrap.
    bus.pc_load = 1'b1; bus.pc_src = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check_vec("inc_pc", 32'(bus.pc), 32'(i));
    end
    bus.pc_src = 2'd1; bus.branch_tgt = 9'h1FF; step();
    check_vec("br_pc", 32'(bus.pc), 32'h1FF);
    bus.pc_src = 2'd0; step();
    check_vec("wrap_pc", 32'(bus.pc), 32'h000);
    bus.pc_src = 2'd2; bus.link_tgt = 9'h0C3; step();
    check_vec("link_pc", 32'(bus.pc), 32'h0C3);
    bus.pc_src = 2'd3; step();
    check_vec("hold_pc", 32'(bus.pc), 32'h0C3);
    bus.pc_src = 2'd1; bus.branch_tgt = 9'h005; step();
    bus.pc_load = 1'b0;

    // Single IRQ on channel 2.
    bus.gie = 1'b1; bus.irq_en = 4'b1111;
    pulse_irq(4'b0100);
    check_vec("single_pend", 32'(bus.pending), 32'b0100);
    bus.iret = 1'b1; step();
    check_vec("run_iret_ignored", 32'(bus.pc), 32'h005);
    bus.iret = 1'b0; bus.boundary = 1'b1; step();
    check_take("single", 9'h018, 2'd2);
    check_vec("single_pend_clr", 32'(bus.pending), 32'd0);
    bus.boundary = 1'b0; step();
    check_vec("single_pulse_end", 32'(bus.irq_take), 32'd0);
    bus.iret = 1'b1; step();
    check_vec("single_ret_pc", 32'(bus.pc), 32'h005);
    check_vec("single_ret_act", 32'(bus.irq_active), 32'd0);
    check_vec("single_id_hold", 32'(bus.irq_id), 32'd2);
    bus.iret = 1'b0;

    // Priority and mask: channel 1 masked, channel 3 wins.
    bus.irq_en = 4'b1101;
    pulse_irq(4'b1010);
    check_vec("prio_pend", 32'(bus.pending), 32'b1010);
    bus.boundary = 1'b1; step();
    check_take("prio3", 9'h01C, 2'd3);
    check_vec("prio_masked_pend", 32'(bus.pending), 32'b0010);
    bus.boundary = 1'b0; bus.iret = 1'b1; step();
    check_vec("prio3_ret", 32'(bus.pc), 32'h005);
    bus.iret = 1'b0; bus.irq_en = 4'b1111; bus.boundary = 1'b1; step();
    check_take("prio1", 9'h014, 2'd1);
    bus.boundary = 1'b0; bus.iret = 1'b1; step();
    bus.iret = 1'b0;

    // gie blocks the take but not the latch.
    bus.gie = 1'b0;
    pulse_irq(4'b0001);
    bus.boundary = 1'b1; step();
    check_vec("gie_no_take", 32'(bus.irq_take), 32'd0);
    check_vec("gie_pend", 32'(bus.pending), 32'b0001);
    check_vec("gie_pc", 32'(bus.pc), 32'h005);
    bus.gie = 1'b1; step();
    check_take("gie_on", 9'h010, 2'd0);
    bus.boundary = 1'b0; bus.iret = 1'b1; step();
    bus.iret = 1'b0;

    // Take coincident with a branch load: vector wins, return to pre-take PC.
    pulse_irq(4'b0001);
    bus.boundary = 1'b1; bus.pc_load = 1'b1; bus.pc_src = 2'd1; bus.branch_tgt = 9'h0AA; step();
    check_take("over_load", 9'h010, 2'd0);
    bus.boundary = 1'b0; bus.pc_load = 1'b0; bus.iret = 1'b1; step();
    check_vec("over_load_ret", 32'(bus.pc), 32'h005);
    bus.iret = 1'b0;

    // Set and clear of the same channel in one cycle: set wins.
    pulse_irq(4'b0100);
    step();
    bus.irq = 4'b0100; bus.boundary = 1'b1; step();
    check_take("setclr", 9'h018, 2'd2);
    check_vec("setclr_pend", 32'(bus.pending), 32'b0100);
    bus.irq = 4'b0000; bus.boundary = 1'b0; bus.iret = 1'b1; step();
    bus.iret = 1'b0; bus.boundary = 1'b1; step();
    check_take("setclr_retake", 9'h018, 2'd2);
    bus.boundary = 1'b0; bus.iret = 1'b1; step();
    bus.iret = 1'b0;

    // Higher-priority request while in the channel-2 ISR.
    pulse_irq(4'b0100);
    bus.boundary = 1'b1; step();
    check_take("isr2_enter", 9'h018, 2'd2);
    bus.boundary = 1'b0;
    pulse_irq(4'b0001);
    check_vec("inisr_pend", 32'(bus.pending), 32'b0001);
    bus.boundary = 1'b1; step();
`ifdef IRQ_NEST_EN
    check_take("nest", 9'h010, 2'd0);
    bus.boundary = 1'b0; bus.iret = 1'b1; step();
    check_vec("nest_pop1_pc", 32'(bus.pc), 32'h018);
    check_vec("nest_pop1_id", 32'(bus.irq_id), 32'd2);
    check_vec("nest_pop1_act", 32'(bus.irq_active), 32'd1);
    step();
    check_vec("nest_pop2_pc", 32'(bus.pc), 32'h005);
    check_vec("nest_pop2_act", 32'(bus.irq_active), 32'd0);
    bus.iret = 1'b0;
`else
    check_vec("inisr_no_take", 32'(bus.irq_take), 32'd0);
    check_vec("inisr_pc", 32'(bus.pc), 32'h018);
    bus.boundary = 1'b0; bus.iret = 1'b1; step();
    check_vec("inisr_ret_pc", 32'(bus.pc), 32'h005);
    check_vec("inisr_ret_act", 32'(bus.irq_active), 32'd0);
    bus.iret = 1'b0; bus.boundary = 1'b1; step();
    check_take("after_iret", 9'h010, 2'd0);
    bus.boundary = 1'b0; bus.iret = 1'b1; step();
    bus.iret = 1'b0;
`endif

    // Asynchronous reset while servicing.
    pulse_irq(4'b0100);
    bus.boundary = 1'b1; step();
`ifdef IRQ_NEST_EN
    bus.boundary = 1'b0;
    pulse_irq(4'b0001);
    bus.boundary = 1'b1; step();
`endif
    bus.boundary = 1'b0;
    pulse_irq(4'b1000);
    #2 reset = 1'b0;
    #1;
    check_vec("mid_rst_pc",      32'(bus.pc),         32'd0);
    check_vec("mid_rst_take",    32'(bus.irq_take),   32'd0);
    check_vec("mid_rst_active",  32'(bus.irq_active), 32'd0);
    check_vec("mid_rst_id",      32'(bus.irq_id),     32'd0);
    check_vec("mid_rst_pending", 32'(bus.pending),    32'd0);
    #3 reset = 1'b1;
    step();
    check_vec("post_rst_pc", 32'(bus.pc), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
